// File: rtl/skew_pkg.sv
// skew_pkg: shared constants and helpers for the multi-lane skew buffer.
//   MODE_SKEW / MODE_DESKEW : values of the mode input / mode_q output
//   lane_depth()            : delay of lane k, in enabled cycles, for a mode
//   max_depth()             : storage stages each lane must hold (MAXD)
package skew_pkg;

    localparam logic MODE_SKEW   = 1'b0;
    localparam logic MODE_DESKEW = 1'b1;

    // Skew staggers lanes upward (lane 0 shortest); deskew mirrors it so
    // the last lane is shortest and early array outputs wait for late ones.
    function automatic int lane_depth(input int k, input logic mode,
                                      input int base_depth, input int skew,
                                      input int channels);
        if (mode == MODE_DESKEW)
            return base_depth + (channels - 1 - k) * skew;
        else
            return base_depth + k * skew;
    endfunction

    function automatic int max_depth(input int base_depth, input int skew,
                                     input int channels);
        return base_depth + (channels - 1) * skew;
    endfunction

endpackage

// File: rtl/skew_buffer_if.sv
// skew_buffer_if: bundle of the skew buffer's data-path signals.
//   en, clr, mode, d, d_valid : producer -> buffer
//   q, q_valid, empty, mode_q : buffer -> consumer
// Valid semantics: d_valid qualifies d for every lane on an edge where
// en=1 and clr=0. There is no ready: the buffer never back-pressures, so
// every enabled edge accepts one slot (valid or bubble). q_valid[k] marks
// q lane k as meaningful; q lane k reads 0 whenever q_valid[k]=0.
interface skew_buffer_if #(
    parameter int CHANNELS = 8,
    parameter int BITS     = 64
);
    logic                     en;
    logic                     clr;
    logic                     mode;
    logic [CHANNELS*BITS-1:0] d;
    logic                     d_valid;
    logic [CHANNELS*BITS-1:0] q;
    logic [CHANNELS-1:0]      q_valid;
    logic                     empty;
    logic                     mode_q;

    modport master (
        output en, clr, mode, d, d_valid,
        input  q, q_valid, empty, mode_q
    );

    modport slave (
        input  en, clr, mode, d, d_valid,
        output q, q_valid, empty, mode_q
    );
endinterface

// File: rtl/skew_lane.sv
// skew_lane: one lane of MAXD {valid, data} stages.
//   clk, rst        : clock, async active-high reset
//   en, clr         : shift enable, synchronous flush (clr wins)
//   d, d_valid      : value entering stage 0 on a shift
//   tap             : stage index driving the output
//   q, q_valid      : tapped stage, data masked to 0 when not valid
//   lane_any_valid  : any stage (tapped or not) holds a valid bit
module skew_lane #(
    parameter int BITS = 64,
    parameter int MAXD = 1,
    parameter int TW   = (MAXD > 1) ? $clog2(MAXD) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            clr,
    input  logic [BITS-1:0] d,
    input  logic            d_valid,
    input  logic [TW-1:0]   tap,
    output logic [BITS-1:0] q,
    output logic            q_valid,
    output logic            lane_any_valid
);
    logic [BITS-1:0] data_r [MAXD];
    logic [MAXD-1:0] vld_r;

    // Data is written even for bubbles; the output mask hides stale values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_r <= '0;
            for (int i = 0; i < MAXD; i++) data_r[i] <= '0;
        end else if (clr) begin
            vld_r <= '0;
            for (int i = 0; i < MAXD; i++) data_r[i] <= '0;
        end else if (en) begin
            vld_r[0]  <= d_valid;
            data_r[0] <= d;
            for (int i = 1; i < MAXD; i++) begin
                vld_r[i]  <= vld_r[i-1];
                data_r[i] <= data_r[i-1];
            end
        end
    end

    assign q_valid        = vld_r[tap];
    assign q              = q_valid ? data_r[tap] : '0;
    assign lane_any_valid = |vld_r;
endmodule

// File: rtl/skew_buffer.sv
// skew_buffer: CHANNELS-lane delay buffer that staggers (skew) or realigns
// (deskew) operands at the systolic array edge. All lanes share en/clr so a
// single enable stalls the whole wavefront.
//   clk, rst : clock, async active-high reset
//   bus      : skew_buffer_if slave (en, clr, mode, d, d_valid in;
//              q, q_valid, empty, mode_q out)
module skew_buffer
    import skew_pkg::*;
#(
    parameter int CHANNELS   = 8,
    parameter int BITS       = 64,
    parameter int BASE_DEPTH = 1,
    parameter int SKEW       = 1
) (
    input  logic              clk,
    input  logic              rst,
    skew_buffer_if.slave      bus
);
    localparam int MAXD = max_depth(BASE_DEPTH, SKEW, CHANNELS);
    localparam int TW   = (MAXD > 1) ? $clog2(MAXD) : 1;

    logic [CHANNELS-1:0] any_valid;
    logic                empty;
    logic                mode_r;

    assign empty = ~|any_valid;

    // Mode only changes while nothing is in flight, so a sample is never
    // read from a tap other than the one its lane depth was planned for.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mode_r <= MODE_SKEW;
        else if (empty)
            mode_r <= bus.mode;
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        localparam int TAP_SKEW   = lane_depth(k, MODE_SKEW,   BASE_DEPTH, SKEW, CHANNELS) - 1;
        localparam int TAP_DESKEW = lane_depth(k, MODE_DESKEW, BASE_DEPTH, SKEW, CHANNELS) - 1;

        logic [TW-1:0]   tap;
        logic [BITS-1:0] lane_q;
        logic            lane_qv;

        assign tap = (mode_r == MODE_DESKEW) ? TW'(TAP_DESKEW) : TW'(TAP_SKEW);

        skew_lane #(
            .BITS (BITS),
            .MAXD (MAXD),
            .TW   (TW)
        ) u_lane (
            .clk            (clk),
            .rst            (rst),
            .en             (bus.en),
            .clr            (bus.clr),
            .d              (bus.d[k*BITS +: BITS]),
            .d_valid        (bus.d_valid),
            .tap            (tap),
            .q              (lane_q),
            .q_valid        (lane_qv),
            .lane_any_valid (any_valid[k])
        );

        assign bus.q[k*BITS +: BITS] = lane_q;
        assign bus.q_valid[k]        = lane_qv;
    end

    assign bus.empty  = empty;
    assign bus.mode_q = mode_r;
endmodule
